mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the ARM-subset core: a Moore state machine that sequences each instruction through fetch, decode, execute and writeback. It also decodes the ALU command and flag-write controls. It sits directly upstream of `condlogic` and supplies its `PCS`, `NextPC`, `RegW`, `MemW` and `FlagW`; `condlogic` gates these by `CondEx`. The remaining outputs drive the datapath multiplexers and enables directly.

## Interface
- No parameters.
- `clk` input 1: core clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Op` input 2: instruction bits [27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `Funct` input 6: instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S (DP) or L (memory).
- `Rd` input 4: destination register field, bits [15:12].
- `PCS` output 1: unconditioned PC-source request to condlogic.
- `NextPC` output 1: unconditional PC increment enable.
- `RegW` output 1: unconditioned register-write request.
- `MemW` output 1: unconditioned memory-write request.
- `FlagW` output 2: [1] writes N/Z, [0] writes C/V.
- `IRWrite` output 1: instruction-register load enable.
- `AdrSrc` output 1: 0 selects PC, 1 selects ALUResult as memory address.
- `ResultSrc` output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` output 2: 00 RD1, 01 PC, 10 ALUOut.
- `ALUSrcB` output 2: 00 RD2, 01 ExtImm, 10 constant 4.
- `ALUControl` output 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `ImmSrc` output 2: equals `Op`.
- `RegSrc` output 2: [0]=(Op==10), [1]=(Op==01).

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECUTER; Op=00 with Funct[5]=1→EXECUTEI; Op=10→BRANCH; Op=11→FETCH, with no strobe asserted.
  - MEMADR: Funct[0]=1→MEMREAD, otherwise MEMWRITE.
  - MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
  - EXECUTER and EXECUTEI→ALUWB→FETCH. BRANCH→FETCH.
- Output table; any unlisted output is 0:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD. This state reads R15 as PC+8.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALU decode active.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALU decode active.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ADD, branch=1.
- PCS = branch | (RegW & Rd==4'hF).
- ALU decode, active only in EXECUTER/EXECUTEI:
  - cmd 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR; any other cmd→ADD.
  - FlagW[1]=S.
  - FlagW[0]=S & (ALUControl is ADD or SUB).
  - Outside these two states, FlagW=00 and ALUControl=ADD.

## Timing
- Latency per instruction: LDR 5 cycles, STR 4, DP 4, B 3, illegal 2.
- `Op`, `Funct` and `Rd` come from the instruction register. They are valid from DECODE until the next FETCH edge.
- Reset: while `rst`=1, the state is forced to FETCH at each edge. All outputs are driven 0 during reset, including IRWrite and NextPC.
- First cycle after `rst` falls: FETCH outputs.
- `rst` asserted mid-instruction: the in-flight instruction is abandoned with no RegW or MemW on the following edge.
- Unreachable state encodings return to FETCH on the next edge with all strobes 0.

## Configuration
- `CTRL_NOWRITE_EN` defined:
  - cmd 1010 (CMP) with S=1 decodes as SUB, FlagW=11.
  - RegW is suppressed in ALUWB, so PCS is 0 even when Rd=15.
- `CTRL_NOWRITE_EN` undefined: cmd 1010 falls back to ADD with a normal ALUWB write.

## Structure
- `ctrl_pkg`:
  - state enum `ctrl_state_t`;
  - ALUControl codes `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_ORR`;
  - cmd codes `CMD_ADD`, `CMD_SUB`, `CMD_AND`, `CMD_ORR`, `CMD_CMP`;
  - Op codes `OP_DP`, `OP_MEM`, `OP_BR`.
- Sub-module `alu_decoder` (combinational):
  - inputs: active flag from the FSM, `Funct`;
  - outputs: `ALUControl`, `FlagW`.
- `mc_controller` holds the state register, next-state logic, output decode, PCS and ImmSrc/RegSrc.

## Test plan
- `rst`=1 for 2 cycles, then released → all outputs 0 during reset. First cycle: IRWrite=1, NextPC=1, ALUSrcB=10; second cycle: DECODE.
- LDR (Op=01, Funct=011001, Rd=3) → states F,D,MEMADR,MEMREAD,MEMWB. RegW=1 only in cycle 5, with ResultSrc=01 and PCS=0.
- STR (Op=01, Funct=011000) → MemW=1 with AdrSrc=1 only in cycle 4, then FETCH.
- ADDS register form (Op=00, Funct=001001, Rd=15) → EXECUTER with ALUControl=00 and FlagW=11. ALUWB then gives RegW=1 and PCS=1.
- ORR immediate without S (Funct=111000) → EXECUTEI with ALUControl=11 and FlagW=00. B (Op=10) → BRANCH with PCS=1 and ALUSrcA=10, back to FETCH after 3 cycles.
- `rst` pulsed during MEMADR of a store → no MemW, FETCH after release. With `CTRL_NOWRITE_EN`, CMP (Funct=010101) gives FlagW=11, ALUControl=01 and RegW=0 in ALUWB.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// CTRL_NOWRITE_EN enables the compare-only (CMP) decode in the users of this package.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } ctrl_state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // A compare only updates flags; it is recognised by cmd plus the S bit.
  function automatic logic is_cmp_s(input logic [5:0] funct);
    return (funct[4:1] == CMD_CMP) && funct[0];
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU command and flag-write decode for the execute states.
// With CTRL_NOWRITE_EN defined, CMP with S=1 decodes as SUB.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       active,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic unused_i_bit;
  assign unused_i_bit = Funct[5];

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (active) begin
      case (Funct[4:1])
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
`ifdef CTRL_NOWRITE_EN
        CMD_CMP: ALUControl = is_cmp_s(Funct) ? ALU_SUB : ALU_ADD;
`endif
        default: ALUControl = ALU_ADD;
      endcase
      // Carry/overflow are only meaningful for arithmetic operations.
      FlagW[1] = Funct[0];
      FlagW[0] = Funct[0] & ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB));
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Moore multicycle control unit: fetch/decode/execute/writeback sequencing.
// CTRL_NOWRITE_EN suppresses the ALUWB register write for CMP.
module mc_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;
  logic        branch;
  logic        alu_active;
  logic        alu_wb_write;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

`ifdef CTRL_NOWRITE_EN
  assign alu_wb_write = ~is_cmp_s(Funct);
`else
  assign alu_wb_write = 1'b1;
`endif

  // Reset overrides every output so nothing strobes while the core is held.
  always_comb begin
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    branch    = 1'b0;
    alu_active = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          IRWrite   = 1'b1;
          NextPC    = 1'b1;
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_MEMADR:  ALUSrcB = 2'b01;
        S_MEMREAD: AdrSrc  = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegW      = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc = 1'b1;
          MemW   = 1'b1;
        end
        S_EXECUTER: alu_active = 1'b1;
        S_EXECUTEI: begin
          ALUSrcB    = 2'b01;
          alu_active = 1'b1;
        end
        S_ALUWB: RegW = alu_wb_write;
        S_BRANCH: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          branch    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .active     (alu_active),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .FlagW      (FlagW)
  );

  assign PCS    = branch | (RegW & (Rd == 4'hF));
  assign ImmSrc = rst ? 2'b00 : Op;
  assign RegSrc = rst ? 2'b00 : {(Op == OP_MEM), (Op == OP_BR)};

endmodule
